// File: rtl/memory_interconnect_if.sv
// Bus bundle between the CPU data port and the memory interconnect, plus the
// fan-out to the downstream regions. The interconnect uses the slave modport.
interface memory_interconnect_if #(
    parameter int REGION_COUNT         = 4,
    parameter int REGION_ADDRESS_WIDTH = 12
);
    logic                            request_valid;
    logic                            request_ready;
    logic [31:0]                     request_address;
    logic [1:0]                      request_size;
    logic                            request_write_enable;
    logic [31:0]                     request_write_value;
    logic                            response_valid;
    logic [31:0]                     response_read_value;
    logic                            response_error;
    logic [REGION_COUNT-1:0]         region_request;
    logic [REGION_ADDRESS_WIDTH-1:0] region_address;
    logic                            region_write_enable;
    logic [3:0]                      region_byte_enable;
    logic [31:0]                     region_write_value;
    logic [REGION_COUNT-1:0]         region_ack;
    logic [32*REGION_COUNT-1:0]      region_read_value;

    modport slave (
        input  request_valid, request_address, request_size,
               request_write_enable, request_write_value,
               region_ack, region_read_value,
        output request_ready, response_valid, response_read_value, response_error,
               region_request, region_address, region_write_enable,
               region_byte_enable, region_write_value
    );

    modport master (
        output request_valid, request_address, request_size,
               request_write_enable, request_write_value,
               region_ack, region_read_value,
        input  request_ready, response_valid, response_read_value, response_error,
               region_request, region_address, region_write_enable,
               region_byte_enable, region_write_value
    );
endinterface

// File: rtl/memory_interconnect.sv
// One-access-at-a-time CPU-to-region interconnect with decode/alignment faults.
// Optional acknowledge timeout: define MEMORY_INTERCONNECT_TIMEOUT_EN.
module memory_interconnect #(
    parameter int REGION_COUNT         = 4,
    parameter int REGION_SELECT_LSB    = 12,
    parameter int REGION_ADDRESS_WIDTH = 12,
    parameter int TIMEOUT_CYCLES       = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    memory_interconnect_if.slave bus
);
    localparam int IDX_W   = $clog2(REGION_COUNT);
    localparam int SEL_TOP = REGION_SELECT_LSB + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPOND
    } state_t;

    generate
        if (REGION_COUNT < 2 || (REGION_COUNT & (REGION_COUNT - 1)) != 0 ||
            TIMEOUT_CYCLES < 1 || REGION_ADDRESS_WIDTH < 2 ||
            REGION_ADDRESS_WIDTH > REGION_SELECT_LSB || SEL_TOP > 32) begin : g_bad_params
            $error("memory_interconnect: illegal parameter combination");
        end
    endgenerate

    state_t                          state_q;
    logic [IDX_W-1:0]                index_q;
    logic [1:0]                      offset_q;
    logic [1:0]                      size_q;
    logic                            write_q;
    logic                            request_ready_q;
    logic                            response_valid_q;
    logic                            response_error_q;
    logic [31:0]                     response_read_value_q;
    logic [REGION_COUNT-1:0]         region_request_q;
    logic [REGION_ADDRESS_WIDTH-1:0] region_address_q;
    logic                            region_write_enable_q;
    logic [3:0]                      region_byte_enable_q;
    logic [31:0]                     region_write_value_q;

    // Decode of the incoming request, consumed only in IDLE.
    logic [IDX_W-1:0]                index_d;
    logic                            decode_error_d;
    logic [3:0]                      byte_enable_d;
    logic [31:0]                     write_value_d;
    logic [REGION_ADDRESS_WIDTH-1:0] region_address_d;
    logic                            upper_nonzero;

    assign index_d          = bus.request_address[SEL_TOP-1 -: IDX_W];
    assign upper_nonzero    = |(bus.request_address >> SEL_TOP);
    assign region_address_d = {bus.request_address[REGION_ADDRESS_WIDTH-1:2], 2'b00};

    always_comb begin
        decode_error_d = upper_nonzero;
        byte_enable_d  = 4'b0000;
        write_value_d  = bus.request_write_value;
        case (bus.request_size)
            2'b00: begin
                byte_enable_d = 4'b0001 << bus.request_address[1:0];
                write_value_d = {4{bus.request_write_value[7:0]}};
            end
            2'b01: begin
                byte_enable_d = bus.request_address[1] ? 4'b1100 : 4'b0011;
                write_value_d = {2{bus.request_write_value[15:0]}};
                if (bus.request_address[0]) decode_error_d = 1'b1;
            end
            2'b10: begin
                byte_enable_d = 4'b1111;
                if (bus.request_address[1:0] != 2'b00) decode_error_d = 1'b1;
            end
            default: decode_error_d = 1'b1;
        endcase
    end

    // Read path: pick the selected region's word, then right-align the lane.
    logic [31:0] lane_word [REGION_COUNT];
    logic [31:0] selected_word;
    logic [31:0] shifted_word;
    logic [31:0] read_value_d;
    logic        ack_selected;

    genvar gi;
    generate
        for (gi = 0; gi < REGION_COUNT; gi++) begin : g_region_mux
            assign lane_word[gi] = (index_q == IDX_W'(gi)) ?
                                   bus.region_read_value[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        selected_word = 32'd0;
        for (int i = 0; i < REGION_COUNT; i++) begin
            selected_word = selected_word | lane_word[i];
        end
    end

    assign shifted_word = selected_word >> {offset_q, 3'b000};
    assign ack_selected = bus.region_ack[index_q];

    always_comb begin
        read_value_d = 32'd0;
        if (!write_q) begin
            case (size_q)
                2'b00:   read_value_d = {24'd0, shifted_word[7:0]};
                2'b01:   read_value_d = {16'd0, shifted_word[15:0]};
                default: read_value_d = shifted_word;
            endcase
        end
    end

    logic timeout_hit;
`ifdef MEMORY_INTERCONNECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_count_q;

    // Counter sits at zero outside ACCESS, so it is clear on every entry.
    always_ff @(posedge clock) begin
        if (reset || state_q != ST_ACCESS) begin
            timeout_count_q <= '0;
        end else if (!ack_selected) begin
            timeout_count_q <= timeout_count_q + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_q == ST_ACCESS) && !ack_selected &&
                         (timeout_count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q               <= ST_IDLE;
            index_q               <= '0;
            offset_q              <= 2'b00;
            size_q                <= 2'b00;
            write_q               <= 1'b0;
            request_ready_q       <= 1'b1;
            response_valid_q      <= 1'b0;
            response_error_q      <= 1'b0;
            response_read_value_q <= 32'd0;
            region_request_q      <= '0;
            region_address_q      <= '0;
            region_write_enable_q <= 1'b0;
            region_byte_enable_q  <= 4'b0000;
            region_write_value_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.request_valid) begin
                        index_q         <= index_d;
                        offset_q        <= bus.request_address[1:0];
                        size_q          <= bus.request_size;
                        write_q         <= bus.request_write_enable;
                        request_ready_q <= 1'b0;
                        if (decode_error_d) begin
                            state_q               <= ST_RESPOND;
                            response_valid_q      <= 1'b1;
                            response_error_q      <= 1'b1;
                            response_read_value_q <= 32'd0;
                        end else begin
                            state_q               <= ST_ACCESS;
                            region_request_q      <= REGION_COUNT'(1) << index_d;
                            region_address_q      <= region_address_d;
                            region_write_enable_q <= bus.request_write_enable;
                            region_byte_enable_q  <= byte_enable_d;
                            region_write_value_q  <= write_value_d;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack coinciding with the timeout still completes normally.
                    if (ack_selected) begin
                        state_q               <= ST_RESPOND;
                        region_request_q      <= '0;
                        response_valid_q      <= 1'b1;
                        response_error_q      <= 1'b0;
                        response_read_value_q <= read_value_d;
                    end else if (timeout_hit) begin
                        state_q               <= ST_RESPOND;
                        region_request_q      <= '0;
                        response_valid_q      <= 1'b1;
                        response_error_q      <= 1'b1;
                        response_read_value_q <= 32'd0;
                    end
                end
                ST_RESPOND: begin
                    state_q          <= ST_IDLE;
                    response_valid_q <= 1'b0;
                    response_error_q <= 1'b0;
                    request_ready_q  <= 1'b1;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    region_request_q <= '0;
                    response_valid_q <= 1'b0;
                    request_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.request_ready       = request_ready_q;
    assign bus.response_valid      = response_valid_q;
    assign bus.response_error      = response_error_q;
    assign bus.response_read_value = response_read_value_q;
    assign bus.region_request      = region_request_q;
    assign bus.region_address      = region_address_q;
    assign bus.region_write_enable = region_write_enable_q;
    assign bus.region_byte_enable  = region_byte_enable_q;
    assign bus.region_write_value  = region_write_value_q;
endmodule

// File: tb/tb_memory_interconnect.sv
// Directed-vector bench for memory_interconnect; the timeout scenario follows
// whether MEMORY_INTERCONNECT_TIMEOUT_EN is defined for the build.
module tb_memory_interconnect;
    localparam int RC  = 4;
    localparam int RAW = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    memory_interconnect_if #(.REGION_COUNT(RC), .REGION_ADDRESS_WIDTH(RAW)) bus ();

    memory_interconnect #(
        .REGION_COUNT(RC),
        .REGION_SELECT_LSB(12),
        .REGION_ADDRESS_WIDTH(RAW),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int compare_count  = 0;
    int mismatch_count = 0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_region_word(input int idx, input logic [31:0] value);
        bus.region_read_value[32*idx +: 32] = value;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [1:0] size,
                         input logic we, input logic [31:0] wdata);
        check_value("ready_before_accept", {31'd0, bus.request_ready}, 32'd1);
        bus.request_valid        = 1'b1;
        bus.request_address      = addr;
        bus.request_size         = size;
        bus.request_write_enable = we;
        bus.request_write_value  = wdata;
        step();
        bus.request_valid = 1'b0;
    endtask

    task automatic note_txn(input string name, input logic [31:0] addr);
        $display("txn %-12s addr=0x%08h resp_valid=%0d err=%0d rdata=0x%08h",
                 name, addr, bus.response_valid, bus.response_error,
                 bus.response_read_value);
    endtask

    logic [31:0] err_addr [4];
    logic [1:0]  err_size [4];
    logic        seen_valid;

    initial begin
        err_addr = '{32'h0000_0001, 32'h0000_0002, 32'h0000_1000, 32'h0001_0000};
        err_size = '{2'b01, 2'b10, 2'b11, 2'b10};

        bus.request_valid        = 1'b0;
        bus.request_address      = 32'd0;
        bus.request_size         = 2'b00;
        bus.request_write_enable = 1'b0;
        bus.request_write_value  = 32'd0;
        bus.region_ack           = '0;
        bus.region_read_value    = '0;

        // Reset state
        step(); step();
        check_value("rst_ready",    {31'd0, bus.request_ready}, 32'd1);
        check_value("rst_valid",    {31'd0, bus.response_valid}, 32'd0);
        check_value("rst_error",    {31'd0, bus.response_error}, 32'd0);
        check_value("rst_rdata",    bus.response_read_value, 32'd0);
        check_value("rst_req",      {28'd0, bus.region_request}, 32'd0);
        check_value("rst_be",       {28'd0, bus.region_byte_enable}, 32'd0);
        check_value("rst_we",       {31'd0, bus.region_write_enable}, 32'd0);
        check_value("rst_addr",     {20'd0, bus.region_address}, 32'd0);
        check_value("rst_wdata",    bus.region_write_value, 32'd0);
        reset = 1'b0;
        step();

        // Word read, region 1, ack in first ACCESS cycle
        issue(32'h0000_1004, 2'b10, 1'b0, 32'd0);
        check_value("w_rd_req",   {28'd0, bus.region_request}, 32'h2);
        check_value("w_rd_be",    {28'd0, bus.region_byte_enable}, 32'hF);
        check_value("w_rd_addr",  {20'd0, bus.region_address}, 32'h004);
        check_value("w_rd_we",    {31'd0, bus.region_write_enable}, 32'd0);
        check_value("w_rd_ready", {31'd0, bus.request_ready}, 32'd0);
        check_value("w_rd_nrsp",  {31'd0, bus.response_valid}, 32'd0);
        set_region_word(1, 32'hDEAD_BEEF);
        bus.region_ack = 4'b0010;
        step();
        bus.region_ack = '0;
        check_value("w_rd_valid", {31'd0, bus.response_valid}, 32'd1);
        check_value("w_rd_err",   {31'd0, bus.response_error}, 32'd0);
        check_value("w_rd_data",  bus.response_read_value, 32'hDEAD_BEEF);
        check_value("w_rd_req0",  {28'd0, bus.region_request}, 32'd0);
        note_txn("word_read", 32'h0000_1004);
        step();
        check_value("w_rd_vdrop", {31'd0, bus.response_valid}, 32'd0);

        // Byte write, region 3, accepted in N+3 of the previous access
        issue(32'h0000_3003, 2'b00, 1'b1, 32'h0000_005A);
        check_value("b_wr_req",   {28'd0, bus.region_request}, 32'h8);
        check_value("b_wr_be",    {28'd0, bus.region_byte_enable}, 32'h8);
        check_value("b_wr_wdata", bus.region_write_value, 32'h5A5A_5A5A);
        check_value("b_wr_we",    {31'd0, bus.region_write_enable}, 32'd1);
        check_value("b_wr_addr",  {20'd0, bus.region_address}, 32'h000);
        set_region_word(3, 32'h1234_5678);
        bus.region_ack = 4'b1000;
        step();
        bus.region_ack = '0;
        check_value("b_wr_valid", {31'd0, bus.response_valid}, 32'd1);
        check_value("b_wr_rdata", bus.response_read_value, 32'd0);
        note_txn("byte_write", 32'h0000_3003);
        step();

        // Half read, upper half of region 3
        issue(32'h0000_3002, 2'b01, 1'b0, 32'd0);
        check_value("h_rd_be",    {28'd0, bus.region_byte_enable}, 32'hC);
        bus.region_ack = 4'b1000;
        step();
        bus.region_ack = '0;
        check_value("h_rd_valid", {31'd0, bus.response_valid}, 32'd1);
        check_value("h_rd_data",  bus.response_read_value, 32'h0000_1234);
        note_txn("half_read", 32'h0000_3002);
        step();

        // Byte read, lane 1 of region 1; half write replication
        set_region_word(1, 32'hAABB_CCDD);
        issue(32'h0000_1001, 2'b00, 1'b0, 32'd0);
        check_value("b_rd_be",    {28'd0, bus.region_byte_enable}, 32'h2);
        bus.region_ack = 4'b0010;
        step();
        bus.region_ack = '0;
        check_value("b_rd_data",  bus.response_read_value, 32'h0000_00CC);
        note_txn("byte_read", 32'h0000_1001);
        step();
        issue(32'h0000_0FFC, 2'b01, 1'b1, 32'hFFFF_BEEF);
        check_value("h_wr_wdata", bus.region_write_value, 32'hBEEF_BEEF);
        check_value("h_wr_be",    {28'd0, bus.region_byte_enable}, 32'h3);
        check_value("h_wr_addr",  {20'd0, bus.region_address}, 32'hFFC);
        bus.region_ack = 4'b0001;
        step();
        bus.region_ack = '0;
        check_value("h_wr_valid", {31'd0, bus.response_valid}, 32'd1);
        note_txn("half_write", 32'h0000_0FFC);
        step();

        // Decode faults
        for (int i = 0; i < 4; i++) begin
            issue(err_addr[i], err_size[i], 1'b0, 32'd0);
            check_value("fault_valid", {31'd0, bus.response_valid}, 32'd1);
            check_value("fault_err",   {31'd0, bus.response_error}, 32'd1);
            check_value("fault_req",   {28'd0, bus.region_request}, 32'd0);
            note_txn("fault", err_addr[i]);
            step();
            check_value("fault_ready", {31'd0, bus.request_ready}, 32'd1);
            check_value("fault_vdrop", {31'd0, bus.response_valid}, 32'd0);
        end

        // Region 2 after 5 wait cycles, region 0 acking spuriously
        set_region_word(0, 32'h1111_1111);
        set_region_word(2, 32'hCAFE_F00D);
        issue(32'h0000_2000, 2'b10, 1'b0, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.region_ack = 4'b0001;
            step();
            seen_valid = seen_valid | bus.response_valid;
        end
        check_value("wait_noresp", {31'd0, seen_valid}, 32'd0);
        check_value("wait_req",    {28'd0, bus.region_request}, 32'h4);
        bus.region_ack = 4'b0101;
        step();
        bus.region_ack = '0;
        check_value("wait_valid", {31'd0, bus.response_valid}, 32'd1);
        check_value("wait_data",  bus.response_read_value, 32'hCAFE_F00D);
        note_txn("wait_read", 32'h0000_2000);
        step();

`ifdef MEMORY_INTERCONNECT_TIMEOUT_EN
        issue(32'h0000_0000, 2'b10, 1'b0, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            seen_valid = seen_valid | bus.response_valid;
        end
        check_value("to_early", {31'd0, seen_valid}, 32'd0);
        step();
        check_value("to_valid", {31'd0, bus.response_valid}, 32'd1);
        check_value("to_err",   {31'd0, bus.response_error}, 32'd1);
        check_value("to_rdata", bus.response_read_value, 32'd0);
        check_value("to_req",   {28'd0, bus.region_request}, 32'd0);
        note_txn("timeout", 32'h0000_0000);
        step();
        issue(32'h0000_0000, 2'b10, 1'b0, 32'd0);
`else
        issue(32'h0000_0000, 2'b10, 1'b0, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            seen_valid = seen_valid | bus.response_valid;
        end
        check_value("stuck_noresp", {31'd0, seen_valid}, 32'd0);
        check_value("stuck_req",    {28'd0, bus.region_request}, 32'h1);
        check_value("stuck_ready",  {31'd0, bus.request_ready}, 32'd0);
        note_txn("stuck", 32'h0000_0000);
`endif

        // Reset during ACCESS, with a coincident ack that must be ignored
        reset = 1'b1;
        bus.region_ack = 4'b0001;
        step();
        reset = 1'b0;
        bus.region_ack = '0;
        check_value("rstacc_req",   {28'd0, bus.region_request}, 32'd0);
        check_value("rstacc_ready", {31'd0, bus.request_ready}, 32'd1);
        check_value("rstacc_valid", {31'd0, bus.response_valid}, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_valid = seen_valid | bus.response_valid;
        end
        check_value("rstacc_norsp", {31'd0, seen_valid}, 32'd0);
        note_txn("reset_abort", 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end
endmodule
